// File: rtl/icache_refill.sv
// Instruction-cache block refill engine: fetches one block byte-by-byte from a
// granted RAM port and delivers the assembled block with a one-cycle pulse.
module icache_refill #(
  parameter int unsigned ADDR_WIDTH  = 17,
  parameter int unsigned BLOCK_WIDTH = 4
) (
  input  logic                                 clkIn,
  input  logic                                 resetIn,
  input  logic                                 missIn,
  input  logic [ADDR_WIDTH-BLOCK_WIDTH-1:0]    missAddrIn,
  input  logic                                 flushIn,
  input  logic                                 grantIn,
  input  logic [7:0]                           ramDataIn,
  output logic                                 reqOut,
  output logic [ADDR_WIDTH-1:0]                ramAddrOut,
  output logic                                 busyOut,
  output logic                                 memDataValid,
  output logic [ADDR_WIDTH-1:BLOCK_WIDTH]      memAddr,
  output logic [(2**BLOCK_WIDTH)*8-1:0]        memDataOut
);

  localparam int unsigned BlockSize = 2 ** BLOCK_WIDTH;
  localparam int unsigned CntW      = BLOCK_WIDTH + 1;
  localparam int unsigned BlkW      = ADDR_WIDTH - BLOCK_WIDTH;

  typedef enum logic [1:0] {StIdle, StFetch, StDone} state_e;

  state_e                 state_q, state_d;
  logic [BlkW-1:0]        blk_q, blk_d;
  logic [CntW-1:0]        issue_q, issue_d;
  logic [CntW-1:0]        recv_q, recv_d;
  logic                   inflight_q, inflight_d;
  logic [BlockSize*8-1:0] buf_q, buf_d;
  logic                   valid_q, valid_d;
  logic [BlkW-1:0]        mem_addr_q, mem_addr_d;
  logic [BlockSize*8-1:0] mem_data_q, mem_data_d;
  logic                   req;

  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    issue_d    = issue_q;
    recv_d     = recv_q;
    inflight_d = 1'b0;
    buf_d      = buf_q;
    valid_d    = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    req        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (missIn && !flushIn) begin
          state_d = StFetch;
          blk_d   = missAddrIn;
          issue_d = '0;
          recv_d  = '0;
        end
      end
      StFetch: begin
        req = (issue_q < CntW'(BlockSize));
        if (flushIn) begin
          // Redirect: drop the partial block and any byte still in flight.
          state_d = StIdle;
          issue_d = '0;
          recv_d  = '0;
        end else begin
          if (req && grantIn) begin
            issue_d    = issue_q + 1'b1;
            inflight_d = 1'b1;
          end
          if (inflight_q) begin
            buf_d[{recv_q[BLOCK_WIDTH-1:0], 3'b000} +: 8] = ramDataIn;
            recv_d = recv_q + 1'b1;
            if (recv_q == CntW'(BlockSize - 1)) begin
              state_d    = StDone;
              valid_d    = 1'b1;
              mem_addr_d = blk_q;
              mem_data_d = buf_d;
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clkIn) begin
    if (!resetIn) begin
      state_q    <= StIdle;
      blk_q      <= '0;
      issue_q    <= '0;
      recv_q     <= '0;
      inflight_q <= 1'b0;
      buf_q      <= '0;
      valid_q    <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      issue_q    <= issue_d;
      recv_q     <= recv_d;
      inflight_q <= inflight_d;
      buf_q      <= buf_d;
      valid_q    <= valid_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign reqOut       = req;
  assign ramAddrOut   = {blk_q, issue_q[BLOCK_WIDTH-1:0]};
  assign busyOut      = (state_q != StIdle);
  assign memDataValid = valid_q;
  assign memAddr      = mem_addr_q;
  assign memDataOut   = mem_data_q;

endmodule
